// File: rtl/rr_mux2_arbiter.sv
// Two-channel round-robin arbiter feeding a single registered output slot.
// It drives the 2:1 mux select and keeps per-channel accepted-word counters.
module rr_mux2_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic last;      // channel of the most recent transfer; 1 out of reset so channel 0 wins the first tie
    logic idle_sel;  // select value shown while nobody requests; 0 until the first transfer
    logic load;
    logic gnt_vld;
    logic gnt;
    logic xfer;

    assign load = ~out_valid | out_ready;

    always_comb begin
        gnt_vld = in0_valid | in1_valid;
        gnt     = 1'b0;
        if (in0_valid && in1_valid) gnt = ~last;
        else if (in1_valid)         gnt = 1'b1;
    end

    // Combinational outputs are forced low while reset is asserted.
    assign sel       = rst_n & (gnt_vld ? gnt : idle_sel);
    assign in0_ready = rst_n & load & gnt_vld & ~gnt & in0_valid;
    assign in1_ready = rst_n & load & gnt_vld &  gnt & in1_valid;
    assign xfer      = in0_ready | in1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last      <= 1'b1;
            idle_sel  <= 1'b0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= gnt ? in1_data : in0_data;
                out_src  <= gnt;
                last     <= gnt;
                idle_sel <= gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (in0_ready) cnt0 <= cnt0 + 1'b1;
            if (in1_ready) cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Directed bench for rr_mux2_arbiter: a priority-list reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_rr_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic       in0_ready, in1_ready, sel, out_valid, out_src;
    logic [7:0] out_data, cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // reference state
    logic       m_valid, m_src, m_last, m_idle;
    logic [7:0] m_data, m_c0, m_c1;

    rr_mux2_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Requesters are tried in priority order; the channel not served last comes first.
    function automatic int pick(input logic v0, input logic v1, input logic last_ch);
        int   order [2];
        logic v [2];
        v[0] = v0;
        v[1] = v1;
        order[0] = last_ch ? 0 : 1;
        order[1] = 1 - order[0];
        if (v[order[0]]) return order[0];
        if (v[order[1]]) return order[1];
        return -1;
    endfunction

    function automatic logic slot_free();
        return !m_valid || out_ready;
    endfunction

    function automatic int winner();
        return pick(in0_valid, in1_valid, m_last);
    endfunction

    function automatic logic exp_sel();
        return (winner() < 0) ? m_idle : (winner() == 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_data <= '0; m_src <= 1'b0;
            m_last <= 1'b1; m_idle <= 1'b0; m_c0 <= '0; m_c1 <= '0;
        end else if (slot_free()) begin
            if (winner() == 0) begin
                m_valid <= 1'b1; m_data <= in0_data; m_src <= 1'b0;
                m_last <= 1'b0; m_idle <= 1'b0; m_c0 <= m_c0 + 8'd1;
            end else if (winner() == 1) begin
                m_valid <= 1'b1; m_data <= in1_data; m_src <= 1'b1;
                m_last <= 1'b1; m_idle <= 1'b1; m_c1 <= m_c1 + 8'd1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle compare, just ahead of the rising edge.
    always @(negedge clk) begin
        #4;
        if (chk_en && rst_n) begin
            chk("sel",       32'(sel),       32'(exp_sel()));
            chk("in0_ready", 32'(in0_ready), 32'(slot_free() && winner() == 0));
            chk("in1_ready", 32'(in1_ready), 32'(slot_free() && winner() == 1));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data",  32'(out_data),  32'(m_data));
            chk("out_src",   32'(out_src),   32'(m_src));
            chk("cnt0",      32'(cnt0),      32'(m_c0));
            chk("cnt1",      32'(cnt1),      32'(m_c1));
        end
    end

    task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic rdy);
        @(negedge clk);
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; chk_en = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;
    endtask

    logic [7:0] alt_exp [4];

    initial begin
        alt_exp[0] = 8'h11; alt_exp[1] = 8'h22; alt_exp[2] = 8'h11; alt_exp[3] = 8'h22;

        // reset state
        do_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt0",      32'(cnt0),      32'd0);
        chk("rst_sel",       32'(sel),       32'd0);

        // single channel
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
            #2 chk("single_in0_ready", 32'(in0_ready), 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2;
        chk("single_out_data", 32'(out_data), 32'hA5);
        chk("single_out_src",  32'(out_src),  32'd0);
        chk("single_cnt0",     32'(cnt0),     32'd4);
        chk("single_cnt1",     32'(cnt1),     32'd0);
        chk("single_sel",      32'(sel),      32'd0);

        // alternation from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
            #2 chk("alt_sel", 32'(sel), 32'(i % 2));
            if (i > 0) begin
                chk("alt_out_data",  32'(out_data),  32'(alt_exp[i-1]));
                chk("alt_out_valid", 32'(out_valid), 32'd1);
            end
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2 chk("alt_out_data_last", 32'(out_data), 32'h22);

        // backpressure
        do_reset();
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        #2 chk("bp_first_load", 32'(in0_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
            #2;
            chk("bp_in0_ready", 32'(in0_ready), 32'd0);
            chk("bp_in1_ready", 32'(in1_ready), 32'd0);
            chk("bp_out_data",  32'(out_data),  32'h11);
            chk("bp_sel",       32'(sel),       32'd1);
        end
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        #2 chk("bp_release_in1_ready", 32'(in1_ready), 32'd1);

        // drain and refill in the same cycle
        cyc(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
        #2;
        chk("dr_in1_ready", 32'(in1_ready), 32'd1);
        chk("dr_out_data",  32'(out_data),  32'h22);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2;
        chk("dr_out_valid", 32'(out_valid), 32'd1);
        chk("dr_out_src",   32'(out_src),   32'd1);
        chk("dr_out_data2", 32'(out_data),  32'h33);

        // counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
            if (i == 255) #2 chk("wrap_cnt1_ff", 32'(cnt1), 32'hFF);
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2;
        chk("wrap_cnt1", 32'(cnt1), 32'd0);
        chk("wrap_cnt0", 32'(cnt0), 32'd0);

        // asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h07, 1'b0, 8'h00, 1'b0);
        #2;
        chk("ar_pre_cnt0",      32'(cnt0),      32'd5);
        chk("ar_pre_out_valid", 32'(out_valid), 32'd1);
        #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_cnt0",      32'(cnt0),      32'd0);
        chk("ar_cnt1",      32'(cnt1),      32'd0);
        chk("ar_sel",       32'(sel),       32'd0);
        chk("ar_in0_ready", 32'(in0_ready), 32'd0);
        @(negedge clk);
        in0_valid = 1'b0;
        rst_n = 1'b1; chk_en = 1'b1;
        cyc(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        #2;
        chk("ar_tie_sel",       32'(sel),       32'd0);
        chk("ar_tie_in0_ready", 32'(in0_ready), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2 chk("ar_tie_out_data", 32'(out_data), 32'h44);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
